// File: rtl/gsu_mem_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gsu_mem_scheduler: shares one SDRAM port between the SNES CPU, GSU ROM    |
// | fetch and GSU RAM access, one access per CLKREF slot.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module gsu_mem_scheduler #(
  parameter logic [7:0] CPU_DUMMY       = 8'h01,
  parameter bit         RAN_ROUND_ROBIN = 1'b1
) (
  input  logic        MCLK,
  input  logic        RST_N,
  input  logic        CLKREF,
  input  logic [23:0] CA,
  input  logic        CPU_RD_N,
  input  logic        CPU_WR_N,
  input  logic        ROMSEL_N,
  input  logic        RAMSEL_N,
  input  logic [7:0]  CPU_DI,
  output logic [7:0]  CPU_DO,
  input  logic        RON,
  input  logic        RAN,
  input  logic        GSU_ROM_REQ,
  input  logic [20:0] GSU_ROM_A,
  output logic        GSU_ROM_ACK,
  input  logic        GSU_RAM_REQ,
  input  logic        GSU_RAM_WE,
  input  logic [16:0] GSU_RAM_A,
  input  logic [7:0]  GSU_RAM_D,
  output logic        GSU_RAM_ACK,
  output logic [7:0]  GSU_Q,
  input  logic [22:0] ROM_MASK,
  input  logic [19:0] BSRAM_MASK,
  output logic        MEM_REQ,
  output logic        MEM_RAM,
  output logic        MEM_WE,
  output logic [22:0] MEM_ADDR,
  output logic [7:0]  MEM_D,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_Q
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_CPU = 2'd0, OWN_ROM = 2'd1, OWN_RAM = 2'd2} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        rd_n_q, wr_n_q;
  logic        pend_q, pend_d, pend_ram_q, pend_ram_d, pend_we_q, pend_we_d;
  logic [20:0] pend_a_q, pend_a_d;
  logic [7:0]  pend_dat_q, pend_dat_d;
  logic        last_ram_q, last_ram_d;
  logic        mem_req_q, mem_req_d, mem_ram_q, mem_ram_d, mem_we_q, mem_we_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_d_q, mem_d_d, cpu_do_q, cpu_do_d, gsu_q_q, gsu_q_d;
  logic        rom_ack_q, rom_ack_d, ram_ack_q, ram_ack_d;

  logic        w_cap, w_cap_ram, w_cap_we, w_cap_owned, w_cap_mem;
  logic [7:0]  w_bank;
  logic [20:0] w_cpu_rom_a, w_cap_a, w_slot_a;
  logic [16:0] w_cpu_ram_a;
  logic        w_slot_pend, w_slot_ram, w_slot_we;
  logic [7:0]  w_slot_dat;
  logic        w_rom_el, w_ram_el, w_pick_ram;
  logic [22:0] w_cpu_mem_addr, w_gsu_rom_addr, w_gsu_ram_addr;

  assign w_bank      = CA[23:16];
  assign w_cap_we    = wr_n_q & ~CPU_WR_N;
  assign w_cap       = ((rd_n_q & ~CPU_RD_N) | w_cap_we) & (~ROMSEL_N | ~RAMSEL_N);
  assign w_cap_ram   = ~RAMSEL_N;
  assign w_cpu_rom_a = (w_bank >= 8'h40 && w_bank <= 8'h5F) ? CA[20:0] : {CA[21:16], CA[14:0]};
  assign w_cpu_ram_a = (w_bank == 8'h70 || w_bank == 8'h71) ? CA[16:0] : {4'b0, CA[12:0]};
  assign w_cap_a     = w_cap_ram ? {4'b0, w_cpu_ram_a} : w_cpu_rom_a;
  assign w_cap_owned = w_cap_ram ? RAN : RON;
  // GSU-owned targets and CPU ROM writes resolve at capture without a memory cycle
  assign w_cap_mem   = ~w_cap_owned & (w_cap_ram | ~w_cap_we);

  // A capture on the arbitration cycle is visible immediately so the CPU wins ties
  assign w_slot_pend = w_cap ? w_cap_mem : pend_q;
  assign w_slot_ram  = w_cap ? w_cap_ram : pend_ram_q;
  assign w_slot_we   = w_cap ? w_cap_we  : pend_we_q;
  assign w_slot_a    = w_cap ? w_cap_a   : pend_a_q;
  assign w_slot_dat  = w_cap ? CPU_DI    : pend_dat_q;

  // A port being acknowledged this cycle still shows its old level request
  assign w_rom_el   = GSU_ROM_REQ & RON & ~rom_ack_q;
  assign w_ram_el   = GSU_RAM_REQ & RAN & ~ram_ack_q;
  assign w_pick_ram = w_ram_el & (~w_rom_el | ~RAN_ROUND_ROBIN | ~last_ram_q);

  assign w_cpu_mem_addr = w_slot_ram ? {3'b0, {3'b0, w_slot_a[16:0]} & BSRAM_MASK}
                                     : ({2'b0, w_slot_a} & ROM_MASK);
  assign w_gsu_rom_addr = {2'b0, GSU_ROM_A} & ROM_MASK;
  assign w_gsu_ram_addr = {3'b0, {3'b0, GSU_RAM_A} & BSRAM_MASK};

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    pend_d     = w_slot_pend;
    pend_ram_d = w_slot_ram;
    pend_we_d  = w_slot_we;
    pend_a_d   = w_slot_a;
    pend_dat_d = w_slot_dat;
    last_ram_d = last_ram_q;
    mem_req_d  = mem_req_q;
    mem_ram_d  = mem_ram_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    cpu_do_d   = cpu_do_q;
    gsu_q_d    = gsu_q_q;
    rom_ack_d  = 1'b0;
    ram_ack_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CLKREF && (w_slot_pend || w_rom_el || w_ram_el)) begin
          state_d   = S_ISSUE;
          mem_req_d = 1'b1;
          if (w_slot_pend) begin
            owner_d    = OWN_CPU;
            mem_ram_d  = w_slot_ram;
            mem_we_d   = w_slot_we;
            mem_addr_d = w_cpu_mem_addr;
            mem_d_d    = w_slot_dat;
            pend_d     = 1'b0;
          end else if (w_pick_ram) begin
            owner_d    = OWN_RAM;
            mem_ram_d  = 1'b1;
            mem_we_d   = GSU_RAM_WE;
            mem_addr_d = w_gsu_ram_addr;
            mem_d_d    = GSU_RAM_D;
            last_ram_d = 1'b1;
          end else begin
            owner_d    = OWN_ROM;
            mem_ram_d  = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = w_gsu_rom_addr;
            mem_d_d    = 8'h00;
            last_ram_d = 1'b0;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        state_d = S_WAIT;
        if (MEM_ACK) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          case (owner_q)
            OWN_CPU: if (!mem_we_q) cpu_do_d = MEM_Q;
            OWN_ROM: begin
              gsu_q_d   = MEM_Q;
              rom_ack_d = 1'b1;
            end
            OWN_RAM: begin
              if (!mem_we_q) gsu_q_d = MEM_Q;
              ram_ack_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_cap && w_cap_owned && !w_cap_we) cpu_do_d = CPU_DUMMY;
  end

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_CPU;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      pend_q     <= 1'b0;
      pend_ram_q <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_a_q   <= '0;
      pend_dat_q <= '0;
      last_ram_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_ram_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      cpu_do_q   <= '0;
      gsu_q_q    <= '0;
      rom_ack_q  <= 1'b0;
      ram_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rd_n_q     <= CPU_RD_N;
      wr_n_q     <= CPU_WR_N;
      pend_q     <= pend_d;
      pend_ram_q <= pend_ram_d;
      pend_we_q  <= pend_we_d;
      pend_a_q   <= pend_a_d;
      pend_dat_q <= pend_dat_d;
      last_ram_q <= last_ram_d;
      mem_req_q  <= mem_req_d;
      mem_ram_q  <= mem_ram_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      cpu_do_q   <= cpu_do_d;
      gsu_q_q    <= gsu_q_d;
      rom_ack_q  <= rom_ack_d;
      ram_ack_q  <= ram_ack_d;
    end
  end

  assign CPU_DO      = cpu_do_q;
  assign GSU_Q       = gsu_q_q;
  assign GSU_ROM_ACK = rom_ack_q;
  assign GSU_RAM_ACK = ram_ack_q;
  assign MEM_REQ     = mem_req_q;
  assign MEM_RAM     = mem_ram_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_D       = mem_d_q;

endmodule
`default_nettype wire

// File: doc/gsu_mem_scheduler.md
# gsu_mem_scheduler

Sequences every SuperFX-cartridge access to the shared SDRAM-backed ROM and BSRAM. It sits between three requesters (SNES CPU, GSU ROM fetch, GSU RAM access) and the single memory port. It applies the GSU's RON/RAN bus-ownership flags, grants one access per CLKREF slot, and returns read data to whichever requester was served.

## Interface
Parameters:
- CPU_DUMMY, 8'h01: value returned to CPU reads of a region currently owned by the GSU.
- RAN_ROUND_ROBIN, 1: 1 = GSU ROM/RAM alternate priority; 0 = GSU RAM always beats GSU ROM.

Ports:
- MCLK  in  1  master clock; all state on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- CLKREF  in  1  one-cycle SDRAM slot strobe; new accesses issue only on a cycle where it is high.
- CA  in  24  CPU address.
- CPU_RD_N, CPU_WR_N  in  1  CPU strobes, active-low.
- ROMSEL_N, RAMSEL_N  in  1  cartridge decode, active-low.
- CPU_DI  in  8  CPU write data.
- CPU_DO  out  8  CPU read data.
- RON, RAN  in  1  GSU owns ROM / RAM bus.
- GSU_ROM_REQ  in  1  level request.
- GSU_ROM_A  in  21  ROM address.
- GSU_ROM_ACK  out  1  one-cycle done pulse.
- GSU_RAM_REQ  in  1  level request.
- GSU_RAM_WE  in  1  1 = write.
- GSU_RAM_A  in  17  RAM address.
- GSU_RAM_D  in  8  RAM write data.
- GSU_RAM_ACK  out  1  one-cycle done pulse.
- GSU_Q  out  8  read data; valid on the ACK cycle and held afterwards.
- ROM_MASK, BSRAM_MASK  in  23/20  address masks.
- MEM_REQ  out  1  memory request level.
- MEM_RAM  out  1  0 = ROM, 1 = BSRAM.
- MEM_WE  out  1  write enable.
- MEM_ADDR  out  23  memory address.
- MEM_D  out  8  write data.
- MEM_ACK  in  1  one-cycle completion pulse.
- MEM_Q  in  8  read data, valid with MEM_ACK.

## Operation
CPU capture:
- A falling edge of CPU_RD_N or CPU_WR_N (registered previous value) while ROMSEL_N=0 or RAMSEL_N=0 latches CA, CPU_DI, the RD/WR direction and the ROM/RAM target into a one-entry pending slot.
- A new edge while the slot is still pending overwrites it; the older access is dropped.
- CPU ROM address: banks $40-$5F → CA[20:0]; otherwise {CA[21:16], CA[14:0]}.
- CPU RAM address: banks $70-$71 → CA[16:0]; otherwise {4'b0, CA[12:0]}.
- If the target is owned by the GSU (ROM with RON=1, RAM with RAN=1), the access completes immediately without using memory:
  - a read loads CPU_DUMMY into CPU_DO;
  - a write is discarded.

Ownership:
- A GSU ROM request is eligible only when RON=1.
- A GSU RAM request is eligible only when RAN=1.
- Ineligible requests wait and are never ACKed until they become eligible.

FSM states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE when CLKREF=1 and any eligible request exists. Priority:
  1. CPU pending.
  2. GSU RAM vs GSU ROM, per RAN_ROUND_ROBIN. When round robin is enabled, the last-served GSU port loses ties; on reset, ROM is treated as last served.
- ISSUE:
  - drive MEM_REQ=1 with the winner's MEM_RAM, MEM_WE, MEM_ADDR and MEM_D;
  - ROM address is ANDed with ROM_MASK; RAM address is ANDed with BSRAM_MASK, zero-extended to 23 bits;
  - go to WAIT the same cycle.
- WAIT:
  - hold all MEM_* outputs stable until MEM_ACK;
  - on MEM_ACK: for a read, load MEM_Q into CPU_DO or GSU_Q; pulse the owner's ACK (CPU owner has none); clear the pending or in-service mark; return to IDLE.
- ROM writes from the CPU are discarded without a memory cycle; MEM_WE is never set with MEM_RAM=0.

## Timing
- Reset values:
  - MEM_REQ=0, MEM_RAM=0, MEM_WE=0, MEM_ADDR=0, MEM_D=0;
  - CPU_DO=8'h00, GSU_Q=8'h00;
  - both ACKs 0;
  - FSM in IDLE, CPU slot empty.
- Issue latency: MEM_REQ rises on the clock edge after the first sampled CLKREF=1 in IDLE with an eligible request.
- GSU ACK asserts the cycle after MEM_ACK; GSU_Q is updated on the same edge.
- At most one memory access is outstanding. The back-to-back minimum is one access per CLKREF period.
- Simultaneous CPU capture and GSU request in the same CLKREF cycle: CPU wins.
- RON/RAN change while an access is in WAIT: the access still completes and ACKs. Eligibility is re-evaluated only in IDLE.
- GSU dropping REQ during WAIT: the access completes; ACK is still pulsed.
- RST_N low mid-access: everything returns to reset values asynchronously; any late MEM_ACK after reset release is ignored in IDLE.

## Test plan
- CPU read ROM $00:8123, RON=0, MEM_Q=8'hA5 → MEM_ADDR=23'h000123, MEM_RAM=0, CPU_DO=8'hA5.
- CPU read $00:FFEA with RON=1 → no MEM_REQ; CPU_DO=8'h01 within 2 cycles.
- GSU RAM write A=17'h1FFFF, D=8'h3C, RAN=1, BSRAM_MASK=20'h07FFF → MEM_WE=1, MEM_ADDR=23'h007FFF, one GSU_RAM_ACK pulse.
- GSU ROM and RAM requests held continuously with round robin → grants alternate RAM, ROM, RAM, ROM across four CLKREF slots.
- CPU RAM write $70:0010 and GSU ROM request in the same CLKREF cycle → CPU issued first (MEM_RAM=1, addr 23'h000010); GSU ROM issued in the next slot.
- Assert RST_N=0 during WAIT, then pulse MEM_ACK after release → no ACK outputs, MEM_REQ=0, FSM in IDLE.
